// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  // Receiver sequencing states. PARITY is only reached when the parity
  // feature is compiled in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. The output
// resets high so that a line in reset looks idle to the receiver.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  // Shift the raw line through two flops; reset to the idle (high) level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_d};
    end
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x (OVERSAMPLE) tick from the baud generator.
// Validates the start bit at mid-bit, samples LSB-first data at bit centres,
// checks the stop bit and emits each word with a one-cycle o_rx_valid pulse.
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit after the
// data bits (even parity when PARITY_ODD=0, odd when PARITY_ODD=1).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int TKW = cnt_width(OVERSAMPLE);
  localparam int BCW = cnt_width(DATA_BITS);

  // Tick counts at which the start bit is re-checked and later bits sampled.
  localparam logic [TKW-1:0] TK_MID  = TKW'(OVERSAMPLE / 2 - 1);
  localparam logic [TKW-1:0] TK_LAST = TKW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

  // Reject configurations the datapath is not built for.
  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: unsupported DATA_BITS/OVERSAMPLE/PARITY_ODD");
  end

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [TKW-1:0]       tk_q, tk_d;
  logic [BCW-1:0]       bc_q, bc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD_BIT = 1'(PARITY_ODD);
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Next-state, counter, shift-register and output-register logic.
  // armed_q blocks a new start while the line stays low after a frame that
  // ended with a low stop bit (break); it re-arms once rx_s is seen high.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    tk_d    = tk_q;
    bc_d    = bc_q;
    shift_d = shift_q;
    armed_d = armed_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif

    if (i_stick) begin
      case (state_q)
        IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            tk_d    = '0;
          end
        end

        START: begin
          if (tk_q == TK_MID) begin
            if (rx_s) begin
              state_d = IDLE;  // glitch shorter than half a bit
            end else begin
              state_d = DATA;
              tk_d    = '0;
              bc_d    = '0;
            end
          end else begin
            tk_d = tk_q + TKW'(1);
          end
        end

        DATA: begin
          if (tk_q == TK_LAST) begin
            tk_d    = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bc_q == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bc_d = bc_q + BCW'(1);
            end
          end else begin
            tk_d = tk_q + TKW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tk_q == TK_LAST) begin
            tk_d      = '0;
            par_bad_d = rx_s ^ (^shift_q) ^ PAR_ODD_BIT;
            state_d   = STOP;
          end else begin
            tk_d = tk_q + TKW'(1);
          end
        end
`endif

        STOP: begin
          if (tk_q == TK_LAST) begin
            tk_d    = '0;
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = ~rx_s;
            armed_d = rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            state_d = IDLE;
          end else begin
            tk_d = tk_q + TKW'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; synchronous reset overrides any tick.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the values from before this clock edge.
    if (!i_rst_n) begin
      state_q <= IDLE;
      tk_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tk_q    <= tk_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_rx_data   = data_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model queues the word and
// flags every transmitted frame must produce; a monitor compares each cycle.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_stick;
  logic       i_rx;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] hold_data = 8'h00;
  logic       hold_ferr = 1'b0;
  logic       hold_perr = 1'b0;
  int         valid_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;
  logic       prev_valid = 1'b0;
  bit         mon_en = 1'b0;

  uart_rx #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stick      (i_stick),
    .i_rx         (i_rx),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Oversample tick: one cycle high out of every four.
  initial begin
    i_stick = 1'b0;
    forever begin
      repeat (3) begin
        @(posedge i_clk);
        #1 i_stick = 1'b0;
      end
      @(posedge i_clk);
      #1 i_stick = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for n tick edges, then step just past the edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge i_clk); while (i_stick !== 1'b1);
    end
    #2;
  endtask

  task automatic send_bit(input logic b, input int nticks);
    i_rx = b;
    wait_ticks(nticks);
  endtask

  // Send one complete frame and queue what the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad);
    exp_t x;
    x.data = d;
    x.ferr = ~stop_ok;
    x.perr = par_bad & PAR_EN;
    exp_q.push_back(x);
    send_bit(1'b0, OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i], OVERSAMPLE);
    if (PAR_EN) send_bit((^d) ^ 1'(PARITY_ODD) ^ par_bad, OVERSAMPLE);
    send_bit(stop_ok, OVERSAMPLE);
  endtask

  // Per-cycle monitor: valid pulses must match the queued frames in order;
  // between pulses the data and flag outputs must hold their last values.
  always @(negedge i_clk) begin
    if (mon_en && i_rst_n) begin
      if (o_rx_valid) begin
        check(!prev_valid, "valid_pulse_width", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          check(exp_q.size() != 0, "unexpected_valid", 32'(o_rx_data), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(o_rx_data === e.data, "rx_data", 32'(o_rx_data), 32'(e.data));
          check(o_frame_err === e.ferr, "frame_err", 32'(o_frame_err), 32'(e.ferr));
          check(o_parity_err === e.perr, "parity_err", 32'(o_parity_err), 32'(e.perr));
          hold_data = e.data;
          hold_ferr = e.ferr;
          hold_perr = e.perr;
        end
        valid_cnt++;
        last_data = o_rx_data;
        last_ferr = o_frame_err;
        last_perr = o_parity_err;
      end else begin
        check(o_rx_data === hold_data && o_frame_err === hold_ferr && o_parity_err === hold_perr,
              "held_outputs", 32'({o_parity_err, o_frame_err, o_rx_data}),
              32'({hold_perr, hold_ferr, hold_data}));
      end
      prev_valid = o_rx_valid;
    end
  end

  task automatic reset_pulse();
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst_n    = 1'b1;
    hold_data  = 8'h00;
    hold_ferr  = 1'b0;
    hold_perr  = 1'b0;
    prev_valid = 1'b0;
  endtask

  initial begin
    int         v0;
    int         gap;
    int         g;
    bit         prev_bad;
    bit         stop_ok;
    bit         par_bad;
    logic [7:0] d;
    logic [7:0] partial;

    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check(o_rx_data === 8'h00, "reset_data", 32'(o_rx_data), 32'h0);
    check(o_rx_valid === 1'b0, "reset_valid", 32'(o_rx_valid), 32'h0);
    check(o_frame_err === 1'b0, "reset_frame_err", 32'(o_frame_err), 32'h0);
    check(o_parity_err === 1'b0, "reset_parity_err", 32'(o_parity_err), 32'h0);
    check(o_busy === 1'b0, "reset_busy", 32'(o_busy), 32'h0);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    wait_ticks(20);

    // Clean frame 0xA5.
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    check(valid_cnt == v0 + 1, "a5_pulse_count", 32'(valid_cnt - v0), 32'd1);
    check(last_data === 8'hA5, "a5_data", 32'(last_data), 32'hA5);
    check(last_ferr === 1'b0, "a5_frame_err", 32'(last_ferr), 32'h0);
    check(o_busy === 1'b0, "a5_busy_after", 32'(o_busy), 32'h0);
    wait_ticks(16);

    // Three-tick low glitch on the idle line.
    v0 = valid_cnt;
    i_rx = 1'b0;
    wait_ticks(1);
    check(o_busy === 1'b1, "glitch_busy_rise", 32'(o_busy), 32'h1);
    wait_ticks(2);
    i_rx = 1'b1;
    wait_ticks(7);
    check(o_busy === 1'b0, "glitch_busy_drop", 32'(o_busy), 32'h0);
    wait_ticks(40);
    check(valid_cnt == v0, "glitch_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Back-to-back 0x00 then 0xFF.
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check(valid_cnt == v0 + 2, "b2b_pulse_count", 32'(valid_cnt - v0), 32'd2);
    check(last_data === 8'hFF, "b2b_last_data", 32'(last_data), 32'hFF);
    check(last_ferr === 1'b0, "b2b_frame_err", 32'(last_ferr), 32'h0);
    wait_ticks(16);

    // 0x3C with low stop bit, then a break of two frame times.
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    check(last_data === 8'h3C, "ferr_data", 32'(last_data), 32'h3C);
    check(last_ferr === 1'b1, "ferr_flag", 32'(last_ferr), 32'h1);
    send_bit(1'b0, 2 * 10 * OVERSAMPLE);
    i_rx = 1'b1;
    wait_ticks(32);
    check(valid_cnt == v0 + 1, "break_no_retrigger", 32'(valid_cnt - v0), 32'd1);
    check(o_busy === 1'b0, "break_busy", 32'(o_busy), 32'h0);

    // Reset after four data bits of 0x81, then a clean 0x5A.
    partial = 8'h81;
    send_bit(1'b0, OVERSAMPLE);
    for (int i = 0; i < 4; i++) send_bit(partial[i], OVERSAMPLE);
    reset_pulse();
    check(o_rx_data === 8'h00, "midreset_data", 32'(o_rx_data), 32'h0);
    check(o_rx_valid === 1'b0, "midreset_valid", 32'(o_rx_valid), 32'h0);
    check(o_frame_err === 1'b0, "midreset_frame_err", 32'(o_frame_err), 32'h0);
    check(o_parity_err === 1'b0, "midreset_parity_err", 32'(o_parity_err), 32'h0);
    check(o_busy === 1'b0, "midreset_busy", 32'(o_busy), 32'h0);
    wait_ticks(32);
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1, 1'b0);
    check(valid_cnt == v0 + 1, "post_reset_count", 32'(valid_cnt - v0), 32'd1);
    check(last_data === 8'h5A, "post_reset_data", 32'(last_data), 32'h5A);
    check(last_ferr === 1'b0, "post_reset_frame_err", 32'(last_ferr), 32'h0);
    wait_ticks(8);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    send_frame(8'h07, 1'b1, 1'b1);
    check(last_perr === 1'b1, "parity_bad", 32'(last_perr), 32'h1);
    wait_ticks(8);
    send_frame(8'h07, 1'b1, 1'b0);
    check(last_perr === 1'b0, "parity_good", 32'(last_perr), 32'h0);
    wait_ticks(8);
`endif

    // Randomised frames, gaps, stop-bit errors and short glitches.
    prev_bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      gap = prev_bad ? int'($urandom_range(24, 2)) : int'($urandom_range(24, 0));
      if (gap > 0) begin
        i_rx = 1'b1;
        wait_ticks(gap);
      end
      if ($urandom_range(9, 0) == 0) begin
        g = int'($urandom_range(6, 1));
        i_rx = 1'b0;
        wait_ticks(g);
        i_rx = 1'b1;
        wait_ticks(20);
      end
      d       = 8'($urandom);
      stop_ok = ($urandom_range(4, 0) != 0);
      par_bad = ($urandom_range(3, 0) == 0);
      send_frame(d, stop_ok, par_bad);
      prev_bad = !stop_ok;
    end

    i_rx = 1'b1;
    wait_ticks(40);
    check(exp_q.size() == 0, "frames_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
